k2_fetch: RTL and testbench

K2_FETCH -- requirements
Module: k2_fetch

---
 rtl/k2_fetch.sv | 85 ++++++++
 tb/tb_k2_fetch.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/k2_fetch.sv
// rtl/k2_fetch.sv - two-phase instruction fetch unit with stall, jump, halt and retire counter
module k2_fetch #(
    parameter logic [3:0] RESET_PC = 4'd0,
    parameter int         CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    output logic [3:0]       rom_addr,
    input  logic [7:0]       rom_data,
    output logic [7:0]       ir,
    output logic             ir_valid,
    output logic [3:0]       pc,
    input  logic             stall,
    input  logic             jump_req,
    input  logic [3:0]       jump_target,
    input  logic             halt_req,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         pc_q, pc_d;
    logic [7:0]         ir_q, ir_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 8'h00;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        case (state_q)
            S_FETCH: begin
                ir_d    = rom_data;
                pc_d    = pc_q + 4'd1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // A cycle with stall low retires the instruction and samples jump/halt.
                if (!stall) begin
                    if (retired_q != {CNT_W{1'b1}}) begin
                        retired_d = retired_q + CNT_W'(1);
                    end
                    if (jump_req) begin
                        pc_d = jump_target;
                    end
                    state_d = halt_req ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign rom_addr = pc_q;
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign retired  = retired_q;
    assign ir_valid = (state_q == S_EXEC);
    assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_k2_fetch.sv
// tb/tb_k2_fetch.sv - randomized and directed checks of k2_fetch against a behavioural model
module tb_k2_fetch;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall;
    logic       jump_req;
    logic [3:0] jump_target;
    logic       halt_req;

    logic [3:0] rom_addr, rom_addr2;
    logic [7:0] rom_data, rom_data2;
    logic [7:0] ir, ir2;
    logic       ir_valid, ir_valid2;
    logic [3:0] pc, pc2;
    logic       halted, halted2;
    logic [7:0] retired;
    logic [1:0] retired2;

    logic [7:0] rom [16];

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0 fetch, 1 exec, 2 halt; retire count kept unbounded.
    int         m_phase;
    int         m_pc;
    int         m_ir;
    int         m_ret;

    always #5 clk = ~clk;

    assign rom_data  = rom[rom_addr];
    assign rom_data2 = rom[rom_addr2];

    k2_fetch #(.RESET_PC(4'd0), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
        .ir(ir), .ir_valid(ir_valid), .pc(pc), .stall(stall),
        .jump_req(jump_req), .jump_target(jump_target), .halt_req(halt_req),
        .halted(halted), .retired(retired)
    );

    k2_fetch #(.RESET_PC(4'd0), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .ir(ir2), .ir_valid(ir_valid2), .pc(pc2), .stall(stall),
        .jump_req(jump_req), .jump_target(jump_target), .halt_req(halt_req),
        .halted(halted2), .retired(retired2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic s, input logic j,
                              input logic [3:0] t, input logic h);
        if (r) begin
            m_phase = 0; m_pc = 0; m_ir = 0; m_ret = 0;
        end else if (m_phase == 0) begin
            m_ir    = rom[m_pc];
            m_pc    = (m_pc + 1) % 16;
            m_phase = 1;
        end else if (m_phase == 1 && !s) begin
            m_ret++;
            if (j) m_pc = t;
            m_phase = h ? 2 : 0;
        end
    endtask

    task automatic check_outputs();
        int sat8 = (m_ret > 255) ? 255 : m_ret;
        int sat2 = (m_ret > 3) ? 3 : m_ret;
        chk("rom_addr", 32'(rom_addr), 32'(m_pc));
        chk("pc",       32'(pc),       32'(m_pc));
        chk("ir",       32'(ir),       32'(m_ir));
        chk("ir_valid", 32'(ir_valid), 32'(m_phase == 1));
        chk("halted",   32'(halted),   32'(m_phase == 2));
        chk("retired",  32'(retired),  32'(sat8));
        chk("pc_sat",   32'(pc2),      32'(m_pc));
        chk("ret_sat",  32'(retired2), 32'(sat2));
    endtask

    task automatic cyc(input logic r, input logic s, input logic j,
                       input logic [3:0] t, input logic h);
        reset = r; stall = s; jump_req = j; jump_target = t; halt_req = h;
        @(posedge clk);
        model_step(r, s, j, t, h);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run_to_exec(input logic [3:0] p);
        for (int k = 0; k < 40; k++) begin
            if (m_phase == 1 && m_pc == 32'(p)) break;
            cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        end
        chk("reach_exec", {27'd0, ir_valid, pc}, {27'd0, 1'b1, p});
    endtask

    initial begin
        for (int a = 0; a < 16; a++) rom[a] = 8'(a);
        m_phase = 0; m_pc = 0; m_ir = 0; m_ret = 0;

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 4'd7, 1'b1);
        chk("rst_valid", 32'(ir_valid), 32'd0);
        chk("rst_addr",  32'(rom_addr), 32'd0);

        // Sequential run with wrap: 17 instructions
        for (int k = 0; k < 34; k++) cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("seq_ret17", 32'(retired), 32'd17);
        chk("seq_sat3",  32'(retired2), 32'd3);
        chk("seq_pc",    32'(pc), 32'd1);

        // Jump from pc=4, with a jump pulse in FETCH that must be ignored
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 4'd12, 1'b0);
        run_to_exec(4'd4);
        chk("jmp_ir3", 32'(ir), 32'h03);
        cyc(1'b0, 1'b0, 1'b1, 4'd9, 1'b0);
        chk("jmp_addr", 32'(rom_addr), 32'd9);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("jmp_ir9", 32'(ir), 32'h09);

        // Stall for 5 cycles with jump asserted, then jump on release
        begin
            logic [7:0] r0;
            r0 = retired;
            for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b1, 4'd2, 1'b0);
            chk("stall_ret", 32'(retired), 32'(r0));
            chk("stall_pc",  32'(pc), 32'd10);
            cyc(1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
            chk("stall_jmp", 32'(pc), 32'd2);
        end

        // Halt with jump to 2
        run_to_exec(4'd5);
        begin
            logic [7:0] r0;
            r0 = retired;
            cyc(1'b0, 1'b0, 1'b1, 4'd2, 1'b1);
            for (int k = 0; k < 6; k++) cyc(1'b0, 1'b0, 1'b1, 4'd7, 1'b1);
            chk("halt_flag", 32'(halted), 32'd1);
            chk("halt_pc",   32'(pc), 32'd2);
            chk("halt_ret",  32'(retired), 32'(r0 + 8'd1));
        end

        // Reset from HALT, then reset mid-EXEC at pc=7
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("rst_halt", {24'd0, halted, pc, 3'd0}, 32'd0);
        run_to_exec(4'd7);
        cyc(1'b1, 1'b0, 1'b1, 4'd3, 1'b1);
        chk("rst_exec", {20'd0, retired, pc}, 32'd0);

        // Random ROM and inputs
        for (int a = 0; a < 16; a++) rom[a] = 8'($urandom);
        for (int k = 0; k < 3000; k++) begin
            if (k % 500 == 0) begin
                for (int a = 0; a < 16; a++) rom[a] = 8'($urandom);
            end
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0),
                4'($urandom),
                ($urandom_range(0, 29) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
